// File: rtl/dump_engine.sv
// dump_engine: serialises a snapshot of one bank into a framed,
// XOR-checksummed byte stream for a UART TX FIFO.
module dump_engine #(
  parameter int BYTE_W    = 8,
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 32,
  parameter int NUM_BANKS = 2,
  localparam int IDX_W = $clog2(NUM_WORDS),
  localparam int SEL_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic [SEL_W-1:0]                    i_bank_sel,
  input  logic [IDX_W-1:0]                    i_first_idx,
  input  logic [IDX_W:0]                      i_count,
  input  logic [NUM_BANKS*NUM_WORDS*WORD_W-1:0] i_banks,
  input  logic [BYTE_W-1:0]                   i_clk_cycle,
  input  logic [WORD_W-1:0]                   i_current_pc,
  input  logic                                i_tx_full,
  output logic                                o_tx_wr,
  output logic [BYTE_W-1:0]                   o_tx_data,
  output logic                                o_busy,
  output logic                                o_done,
  output logic                                o_error
);

  localparam int PB        = WORD_W / BYTE_W;
  localparam int HDR_N     = 3 + PB;
  localparam int POS_W     = $clog2(HDR_N + 1);
  localparam int BANK_BITS = NUM_WORDS * WORD_W;
  localparam logic [BYTE_W-1:0] SYNC = BYTE_W'(8'hA5);

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_INDEX, S_DATA, S_CHECKSUM, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SEL_W-1:0]     bank_q, bank_d;
  logic [BYTE_W-1:0]    cyc_q, cyc_d;
  logic [WORD_W-1:0]    pc_q, pc_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W:0]       cnt_q, cnt_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [BYTE_W-1:0]    csum_q, csum_d;
  logic [BANK_BITS-1:0] snap_q, snap_d;
  logic                 err_q, err_d;

  logic [BYTE_W-1:0]    tx_byte;
  logic [WORD_W-1:0]    word;
  logic                 emit;

  // Byte k (0 = most significant) of a word.
  function automatic logic [BYTE_W-1:0] byte_of(
    input logic [WORD_W-1:0] w,
    input int                k
  );
    logic [WORD_W-1:0] s;
    s = w >> (BYTE_W * (PB - 1 - k));
    return s[BYTE_W-1:0];
  endfunction

  // Select the byte for the current frame position.
  always_comb begin
    tx_byte = '0;
    word    = snap_q[idx_q*WORD_W +: WORD_W];
    unique case (state_q)
      S_HEADER: begin
        unique case (1'b1)
          pos_q == POS_W'(0): tx_byte = SYNC;
          pos_q == POS_W'(1): tx_byte = BYTE_W'(bank_q);
          pos_q == POS_W'(2): tx_byte = cyc_q;
          default:            tx_byte = byte_of(pc_q, int'(pos_q) - 3);
        endcase
      end
      S_INDEX:    tx_byte = BYTE_W'(idx_q);
      S_DATA:     tx_byte = byte_of(word, int'(pos_q));
      S_CHECKSUM: tx_byte = csum_q;
      default:    tx_byte = '0;
    endcase
  end

  // Next-state logic: snapshot on start, advance one byte per free slot.
  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    cyc_d   = cyc_q;
    pc_d    = pc_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    csum_d  = csum_q;
    snap_d  = snap_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (32'(i_bank_sel) < NUM_BANKS) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
              if (i_bank_sel == SEL_W'(b)) begin
                snap_d = i_banks[b*BANK_BITS +: BANK_BITS];
              end
            end
            bank_d  = i_bank_sel;
            cyc_d   = i_clk_cycle;
            pc_d    = i_current_pc;
            idx_d   = i_first_idx;
            cnt_d   = i_count;
            pos_d   = '0;
            csum_d  = '0;
            state_d = S_HEADER;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_HEADER: begin
        if (!i_tx_full) begin
          csum_d = csum_q ^ tx_byte;
          if (pos_q == POS_W'(HDR_N - 1)) begin
            pos_d   = '0;
            state_d = (cnt_q == '0) ? S_CHECKSUM : S_INDEX;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      S_INDEX: begin
        if (!i_tx_full) begin
          csum_d  = csum_q ^ tx_byte;
          pos_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!i_tx_full) begin
          csum_d = csum_q ^ tx_byte;
          if (pos_q == POS_W'(PB - 1)) begin
            pos_d   = '0;
            idx_d   = idx_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = (cnt_q == (IDX_W+1)'(1)) ? S_CHECKSUM : S_INDEX;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      S_CHECKSUM: begin
        if (!i_tx_full) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      bank_q  <= '0;
      cyc_q   <= '0;
      pc_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      csum_q  <= '0;
      snap_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      cyc_q   <= cyc_d;
      pc_q    <= pc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      csum_q  <= csum_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
    end
  end

  assign emit      = (state_q == S_HEADER) || (state_q == S_INDEX) ||
                     (state_q == S_DATA) || (state_q == S_CHECKSUM);
  assign o_tx_wr   = emit && !i_tx_full;
  assign o_tx_data = tx_byte;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_error   = err_q;

endmodule

// File: tb/tb_dump_engine.sv
// tb_dump_engine: scoreboard bench for dump_engine; expected
// bytes/pulses with their cycle are queued, a monitor pops them.
module tb_dump_engine;

  localparam int NB = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       bank_sel;
  logic [4:0]       first;
  logic [5:0]       count;
  logic [NB*1024-1:0] banks;
  logic [7:0]       clk_cycle;
  logic [31:0]      pc;
  logic             tx_full;
  logic             tx_wr;
  logic [7:0]       tx_data;
  logic             busy;
  logic             done;
  logic             error;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t        q[$];
  logic [7:0] bq[$];
  logic [7:0] v037[13];
  int         cyc = 0;
  int         flo = 1;
  int         fhi = 0;
  int         checks = 0;
  int         errors = 0;

  dump_engine #(.NUM_BANKS(NB)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_start     (start),
    .i_bank_sel  (bank_sel),
    .i_first_idx (first),
    .i_count     (count),
    .i_banks     (banks),
    .i_clk_cycle (clk_cycle),
    .i_current_pc(pc),
    .i_tx_full   (tx_full),
    .o_tx_wr     (tx_wr),
    .o_tx_data   (tx_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign tx_full = (cyc >= flo) && (cyc <= fhi);

  task automatic got(input int kind, input logic [7:0] d);
    ev_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: kind=%0d data=%02h cyc=%0d, required none",
               kind, d, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.data != d || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d data=%02h cyc=%0d, required kind=%0d data=%02h cyc=%0d",
                 kind, d, cyc, e.kind, e.data, e.cyc);
      end
    end
  endtask

  // Monitor: every write, done and error pulse is matched in order.
  always @(negedge clk) begin
    if (tx_wr) begin
      checks++;
      if (tx_full || !busy) begin
        errors++;
        $display("FAIL wr_qual: full=%0b busy=%0b, required full=0 busy=1",
                 tx_full, busy);
      end
      got(0, tx_data);
    end
    if (done)  got(1, 8'h00);
    if (error) got(2, 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wval(input int b, input int k);
    if (b == 0 && k == 3) return 32'h11223344;
    return {8'(b + 1), 8'(k), 8'(k ^ 8'h5A), 8'(k * 7)};
  endfunction

  // Reference frame built from the request fields.
  task automatic build(input int bank, input int fi, input int cnt,
                       input logic [7:0] cy, input logic [31:0] p);
    logic [7:0]  cs;
    logic [31:0] w;
    int          idx;
    bq.delete();
    bq.push_back(8'hA5);
    bq.push_back(8'(bank));
    bq.push_back(cy);
    for (int j = 3; j >= 0; j--) bq.push_back(p[j*8 +: 8]);
    for (int i = 0; i < cnt; i++) begin
      idx = (fi + i) % 32;
      bq.push_back(8'(idx));
      w = banks[(bank*32 + idx)*32 +: 32];
      for (int j = 3; j >= 0; j--) bq.push_back(w[j*8 +: 8]);
    end
    cs = 8'h00;
    foreach (bq[i]) cs = cs ^ bq[i];
    bq.push_back(cs);
  endtask

  // Place bytes in cycles, skipping cycles where the FIFO is full.
  task automatic sched(input int t0, input int keep, input bit with_done);
    int c;
    c = t0 + 1;
    for (int i = 0; i < bq.size() && i < keep; i++) begin
      while (c >= flo && c <= fhi) c++;
      q.push_back('{0, bq[i], c});
      c++;
    end
    if (with_done) q.push_back('{1, 8'h00, c});
    bq.delete();
  endtask

  task automatic do_start(input int b, input int fi, input int cnt,
                          input logic [7:0] cy, input logic [31:0] p,
                          output int t);
    @(posedge clk);
    #1;
    bank_sel  = 2'(b);
    first     = 5'(fi);
    count     = 6'(cnt);
    clk_cycle = cy;
    pc        = p;
    start     = 1'b1;
    t         = cyc;
  endtask

  task automatic end_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d events outstanding, required 0",
               name, q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int t;
    v037 = '{8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h10,
             8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hF7};
    for (int b = 0; b < NB; b++)
      for (int k = 0; k < 32; k++)
        banks[(b*32 + k)*32 +: 32] = wval(b, k);
    rst = 1'b1;
    start = 1'b0;
    bank_sel = '0;
    first = '0;
    count = '0;
    clk_cycle = '0;
    pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_wr", 32'(tx_wr), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single word, hand-computed frame.
    do_start(0, 3, 1, 8'h05, 32'h10, t);
    foreach (v037[i]) bq.push_back(v037[i]);
    sched(t, 99, 1);
    end_start();
    drain("basic");

    // Same request with FIFO full during t+2..t+5.
    do_start(0, 3, 1, 8'h05, 32'h10, t);
    flo = t + 2;
    fhi = t + 5;
    foreach (v037[i]) bq.push_back(v037[i]);
    sched(t, 99, 1);
    end_start();
    drain("stall");
    flo = 1;
    fhi = 0;

    // Wrap-around indices; inputs change after the snapshot.
    do_start(1, 30, 4, 8'h3C, 32'hDEADBEEF, t);
    build(1, 30, 4, 8'h3C, 32'hDEADBEEF);
    chk("wrap_idx0", 32'(bq[7]), 32'h1E);
    chk("wrap_idx3", 32'(bq[22]), 32'h01);
    sched(t, 99, 1);
    end_start();
    banks[(1*32 + 31)*32 +: 32] = 32'hCAFEF00D;
    pc = 32'h0;
    clk_cycle = 8'h00;
    bank_sel = 2'd0;
    drain("wrap");
    banks[(1*32 + 31)*32 +: 32] = wval(1, 31);

    // Empty payload.
    do_start(2, 5, 0, 8'hFF, 32'h12345678, t);
    build(2, 5, 0, 8'hFF, 32'h12345678);
    chk("count0_len", bq.size(), 8);
    sched(t, 99, 1);
    end_start();
    drain("count0");

    // Invalid bank.
    do_start(3, 0, 2, 8'h01, 32'h1, t);
    q.push_back('{2, 8'h00, t + 1});
    end_start();
    @(negedge clk);
    chk("err_busy", 32'(busy), 0);
    drain("error");

    // Second start mid-frame is ignored.
    do_start(0, 0, 2, 8'h77, 32'h0000ABCD, t);
    build(0, 0, 2, 8'h77, 32'h0000ABCD);
    sched(t, 99, 1);
    end_start();
    repeat (3) @(posedge clk);
    do_start(1, 7, 5, 8'h99, 32'h55555555, t);
    end_start();
    drain("ignore");

    // Reset after the fifth byte aborts the frame.
    do_start(0, 3, 2, 8'h42, 32'h80000001, t);
    build(0, 3, 2, 8'h42, 32'h80000001);
    sched(t, 5, 0);
    end_start();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_wr", 32'(tx_wr), 0);
    chk("abort_busy", 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("abort_pending", q.size(), 0);
    drain("abort");

    do_start(0, 3, 2, 8'h42, 32'h80000001, t);
    build(0, 3, 2, 8'h42, 32'h80000001);
    sched(t, 99, 1);
    end_start();
    drain("after_abort");

    chk("final_queue", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
